// File: rtl/sap_clock_ctrl.sv
// sap_clock_ctrl: clock-enable generator for the SAP datapath.
// Produces single-cycle clock_sap_en pulses in manual (debounced key0),
// auto (periodic) or burst (N pulses per key press) modes, with halt and
// programming-mode suppression.
// Ports:
//   clock_fpga, reset_n      system clock, async active-low reset
//   mode[1:0]                00 manual, 01 auto, 10 burst, 11 hold
//   div_value                tick period = div_value+1 cycles
//   burst_len                pulses per burst
//   key0                     raw active-low pushbutton (asynchronous)
//   prog_run                 0 suppresses all pulses
//   hlt_sig                  halt request from control unit
//   clock_sap_en             registered clock-enable pulse
//   clock_led                toggles on every pulse
//   pulse_count              pulses emitted (wrapping)
//   busy / halted            state == BURST / state == HALTED
module sap_clock_ctrl #(
  parameter int unsigned DIV_WIDTH       = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                   clock_fpga,
  input  logic                   reset_n,
  input  logic [1:0]             mode,
  input  logic [DIV_WIDTH-1:0]   div_value,
  input  logic [COUNT_WIDTH-1:0] burst_len,
  input  logic                   key0,
  input  logic                   prog_run,
  input  logic                   hlt_sig,
  output logic                   clock_sap_en,
  output logic                   clock_led,
  output logic [COUNT_WIDTH-1:0] pulse_count,
  output logic                   busy,
  output logic                   halted
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AUTO   = 2'd1,
    ST_BURST  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  logic                   sync1_q, sync1_d, sync2_q, sync2_d;
  logic                   key_db_q, key_db_d, key_db_prev_q;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d, div_step_c;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   en_q, en_d;
  logic                   led_q, led_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   busy_q, busy_d;
  logic                   halted_q, halted_d;
  logic                   press_c, div_term_c, div_over_c;

  // Key synchronizer and debouncer; any agreement with the current level restarts the count.
  always_comb begin
    sync1_d  = key0;
    sync2_d  = sync1_q;
    key_db_d = key_db_q;
    db_cnt_d = '0;
    if (sync2_q != key_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Press is the first cycle the debounced level reads low after being high.
  assign press_c = key_db_prev_q & ~key_db_q;

  // Divider terminal count; a divider already past a lowered div_value wraps silently.
  assign div_term_c = (div_q == div_value);
  assign div_over_c = (div_q > div_value);
  assign div_step_c = (div_term_c || div_over_c) ? '0 : div_q + DIV_WIDTH'(1);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    remaining_d = remaining_q;
    en_d        = 1'b0;
    if (hlt_sig) begin
      state_d     = ST_HALTED;
      div_d       = '0;
      remaining_d = '0;
    end else if (!prog_run) begin
      state_d     = ST_IDLE;
      div_d       = '0;
      remaining_d = '0;
    end else begin
      case (state_q)
        ST_HALTED: begin
          state_d = ST_IDLE;
          div_d   = '0;
        end
        ST_IDLE: begin
          div_d = '0;
          case (mode)
            MODE_MANUAL: en_d = press_c;
            MODE_AUTO:   state_d = ST_AUTO;
            MODE_BURST: begin
              if (press_c && (burst_len != '0)) begin
                remaining_d = burst_len;
                state_d     = ST_BURST;
              end
            end
            MODE_HOLD:   ;
            default:     ;
          endcase
        end
        ST_AUTO: begin
          if (mode != MODE_AUTO) begin
            state_d = ST_IDLE;
            div_d   = '0;
          end else begin
            div_d = div_step_c;
            en_d  = div_term_c;
          end
        end
        ST_BURST: begin
          if (mode != MODE_BURST) begin
            state_d     = ST_IDLE;
            div_d       = '0;
            remaining_d = '0;
          end else begin
            div_d = div_step_c;
            if (div_term_c) begin
              en_d        = 1'b1;
              remaining_d = remaining_q - COUNT_WIDTH'(1);
              if (remaining_q == COUNT_WIDTH'(1)) begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          div_d   = '0;
        end
      endcase
    end
    count_d  = count_q + COUNT_WIDTH'(en_d);
    led_d    = led_q ^ en_d;
    busy_d   = (state_d == ST_BURST);
    halted_d = (state_d == ST_HALTED);
  end

  // State and output registers.
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b1;
      db_cnt_q      <= '0;
      state_q       <= ST_IDLE;
      div_q         <= '0;
      remaining_q   <= '0;
      en_q          <= 1'b0;
      led_q         <= 1'b0;
      count_q       <= '0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_q;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      div_q         <= div_d;
      remaining_q   <= remaining_d;
      en_q          <= en_d;
      led_q         <= led_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
    end
  end

  assign clock_sap_en = en_q;
  assign clock_led    = led_q;
  assign pulse_count  = count_q;
  assign busy         = busy_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_sap_clock_ctrl.sv
// Testbench for sap_clock_ctrl with DEBOUNCE_CYCLES=4: table-driven key-press
// and auto-mode vectors plus directed halt, burst, programming and reset sequences.
module tb_sap_clock_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] div_value = '0;
  logic [CW-1:0] burst_len = '0;
  logic          key0 = 1'b1;
  logic          prog_run = 1'b1;
  logic          hlt_sig = 1'b0;
  logic          clock_sap_en, clock_led, busy, halted;
  logic [CW-1:0] pulse_count;

  sap_clock_ctrl #(.DIV_WIDTH(DW), .DEBOUNCE_CYCLES(4), .COUNT_WIDTH(CW)) dut (
    .clock_fpga(clk), .reset_n(reset_n), .mode(mode), .div_value(div_value),
    .burst_len(burst_len), .key0(key0), .prog_run(prog_run), .hlt_sig(hlt_sig),
    .clock_sap_en(clock_sap_en), .clock_led(clock_led), .pulse_count(pulse_count),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Pulse monitor: logs the cycle and busy level of every pulse, sampled mid-cycle.
  int cyc = 0;
  int pulse_log[$];
  bit busy_log[$];
  int busy_cycles = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (clock_sap_en) begin
      pulse_log.push_back(cyc);
      busy_log.push_back(busy);
    end
    if (busy) busy_cycles++;
  end

  int n_checks = 0;
  int n_fail = 0;
  int exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_mon();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (clock_sap_en) break;
    end
  endtask

  task automatic key_press(input int bounces, input int hold);
    for (int b = 0; b < bounces; b++) begin
      key0 = 1'b0; tick();
      key0 = 1'b1; tick();
    end
    key0 = 1'b0;
    repeat (hold) tick();
    key0 = 1'b1;
    repeat (8) tick();
  endtask

  task automatic check_counters(input string name);
    check({name, " pulse_count"}, 32'(pulse_count), 32'(exp_count % 256));
    check({name, " clock_led"}, 32'(clock_led), 32'(exp_count % 2));
  endtask

  task automatic check_window(input string name, input int base, input int exp_n, input int exp_gap);
    int n, gmin, gmax;
    n = pulse_log.size() - base;
    check({name, " pulses"}, 32'(n), 32'(exp_n));
    if (exp_gap > 0 && n >= 2) begin
      gmin = 1000000; gmax = 0;
      for (int i = base + 1; i < pulse_log.size(); i++) begin
        if (pulse_log[i] - pulse_log[i-1] < gmin) gmin = pulse_log[i] - pulse_log[i-1];
        if (pulse_log[i] - pulse_log[i-1] > gmax) gmax = pulse_log[i] - pulse_log[i-1];
      end
      check({name, " min gap"}, 32'(gmin), 32'(exp_gap));
      check({name, " max gap"}, 32'(gmax), 32'(exp_gap));
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    int         blen;
    int         div;
    int         bounces;
    int         hold;
    int         exp_pulses;
    int         exp_busy;
    int         exp_gap;
  } press_vec_t;

  typedef struct {
    int div;
    int win;
    int exp_lat;
    int exp_pulses;
  } auto_vec_t;

  press_vec_t pv[6];
  auto_vec_t  av[4];

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, bbase, lat;
    logic [4:0] hist;

    pv[0] = '{2'b00, 0, 0, 3, 10, 1, 0, 0};
    pv[1] = '{2'b00, 0, 0, 0, 6, 1, 0, 0};
    pv[2] = '{2'b11, 0, 0, 0, 6, 0, 0, 0};
    pv[3] = '{2'b10, 0, 0, 0, 6, 0, 0, 0};
    pv[4] = '{2'b10, 3, 2, 0, 6, 3, 1, 3};
    pv[5] = '{2'b00, 0, 5, 1, 8, 1, 0, 0};
    av[0] = '{3, 40, 5, 10};
    av[1] = '{0, 10, 2, 10};
    av[2] = '{1, 9, 3, 5};
    av[3] = '{6, 15, 8, 3};

    // Reset state and clean release
    repeat (3) tick();
    check("rst clock_sap_en", 32'(clock_sap_en), 0);
    check("rst clock_led", 32'(clock_led), 0);
    check("rst pulse_count", 32'(pulse_count), 0);
    check("rst busy", 32'(busy), 0);
    check("rst halted", 32'(halted), 0);
    #3 reset_n = 1'b1;
    base = pulse_log.size();
    repeat (10) tick();
    sync_mon();
    check_window("post-release", base, 0, 0);

    // Key-press table: manual, hold, burst
    for (int i = 0; i < 6; i++) begin
      mode = pv[i].mode;
      burst_len = CW'(pv[i].blen);
      div_value = DW'(pv[i].div);
      tick(); tick();
      base = pulse_log.size();
      bbase = busy_cycles;
      key_press(pv[i].bounces, pv[i].hold);
      repeat (20) tick();
      sync_mon();
      exp_count += pv[i].exp_pulses;
      check_window($sformatf("press%0d", i), base, pv[i].exp_pulses, pv[i].exp_gap);
      check($sformatf("press%0d busy_seen", i), 32'(busy_cycles > bbase), 32'(pv[i].exp_busy));
      check_counters($sformatf("press%0d", i));
    end

    // Auto-mode table
    for (int i = 0; i < 4; i++) begin
      mode = 2'b11;
      div_value = DW'(av[i].div);
      repeat (3) tick();
      base = pulse_log.size();
      mode = 2'b01;
      wait_pulse(40, lat);
      check($sformatf("auto%0d latency", i), 32'(lat), 32'(av[i].exp_lat));
      repeat (av[i].win - 1) tick();
      sync_mon();
      exp_count += av[i].exp_pulses;
      check_window($sformatf("auto%0d", i), base, av[i].exp_pulses, av[i].div + 1);
      check_counters($sformatf("auto%0d", i));
      mode = 2'b11;
      repeat (3) tick();
    end

    // div_value lowered below the running divider: silent wrap, then new period
    div_value = 8'd7;
    mode = 2'b01;
    wait_pulse(30, lat);
    check("divwrap first latency", 32'(lat), 9);
    repeat (5) tick();
    base = pulse_log.size();
    div_value = 8'd2;
    wait_pulse(20, lat);
    check("divwrap next latency", 32'(lat), 4);
    sync_mon();
    check_window("divwrap", base, 1, 0);
    exp_count += 2;
    mode = 2'b11;
    repeat (3) tick();
    check_counters("divwrap");

    // Halt during auto mode
    div_value = 8'd3;
    mode = 2'b01;
    wait_pulse(20, lat);
    check("halt pre latency", 32'(lat), 5);
    exp_count += 1;
    tick();
    base = pulse_log.size();
    hlt_sig = 1'b1;
    tick(); check("halt cyc1 halted", 32'(halted), 1);
    tick(); check("halt cyc2 halted", 32'(halted), 1);
    tick(); check("halt cyc3 halted", 32'(halted), 1);
    hlt_sig = 1'b0;
    tick(); check("halt release halted", 32'(halted), 0);
    sync_mon();
    check_window("halt window", base, 0, 0);
    wait_pulse(20, lat);
    check("halt resume latency", 32'(lat), 5);
    exp_count += 1;
    mode = 2'b11;
    repeat (3) tick();
    check_counters("halt");

    // Burst of 5 with a second press landing mid-burst
    mode = 2'b10;
    burst_len = 8'd5;
    div_value = 8'd1;
    tick(); tick();
    base = pulse_log.size();
    key0 = 1'b0; repeat (4) tick();
    key0 = 1'b1; repeat (4) tick();
    key0 = 1'b0; repeat (4) tick();
    key0 = 1'b1;
    check("burst busy mid", 32'(busy), 1);
    repeat (20) tick();
    sync_mon();
    check_window("burst", base, 5, 2);
    hist = '0;
    for (int k = 0; k < 5; k++) begin
      if (base + k < busy_log.size()) hist[k] = busy_log[base + k];
    end
    check("burst busy at pulses", 32'(hist), 32'h0F);
    check("burst busy end", 32'(busy), 0);
    exp_count += 5;
    check_counters("burst");

    // Programming mode suppresses everything
    mode = 2'b11;
    tick();
    prog_run = 1'b0;
    mode = 2'b01;
    div_value = 8'd0;
    repeat (3) tick();
    base = pulse_log.size();
    key_press(0, 6);
    mode = 2'b00;
    key_press(0, 6);
    repeat (5) tick();
    sync_mon();
    check_window("prog", base, 0, 0);
    check("prog busy", 32'(busy), 0);
    check_counters("prog");
    mode = 2'b11;
    tick();
    prog_run = 1'b1;
    repeat (3) tick();

    // Asynchronous reset mid-burst
    mode = 2'b10;
    burst_len = 8'd5;
    div_value = 8'd1;
    tick();
    key0 = 1'b0; repeat (4) tick();
    key0 = 1'b1;
    wait_pulse(20, lat);
    check("rstburst first latency", 32'(lat), 5);
    tick();
    check("rstburst busy before", 32'(busy), 1);
    #3 reset_n = 1'b0;
    #2;
    check("rstburst clock_sap_en", 32'(clock_sap_en), 0);
    check("rstburst clock_led", 32'(clock_led), 0);
    check("rstburst pulse_count", 32'(pulse_count), 0);
    check("rstburst busy", 32'(busy), 0);
    check("rstburst halted", 32'(halted), 0);
    exp_count = 0;
    #10 reset_n = 1'b1;
    base = pulse_log.size();
    repeat (20) tick();
    sync_mon();
    check_window("rstburst idle", base, 0, 0);
    check("rstburst busy idle", 32'(busy), 0);
    check_counters("rstburst idle");
    base = pulse_log.size();
    key0 = 1'b0; repeat (4) tick();
    key0 = 1'b1;
    repeat (25) tick();
    sync_mon();
    check_window("rstburst new", base, 5, 2);
    exp_count += 5;
    check_counters("rstburst new");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_clock_ctrl.md
SAP_CLOCK_CTRL -- requirements
Module: sap_clock_ctrl

Interface
REQ-001 Parameter DIV_WIDTH, default 24: width of auto-mode period divisor.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a new key0 level; legal range >=1.
REQ-003 Parameter COUNT_WIDTH, default 16: width of burst length and pulse counter.
REQ-004 clock_fpga  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  2  00 manual single-step, 01 auto, 10 burst, 11 hold (no pulses).
REQ-007 div_value  input  DIV_WIDTH  auto/burst tick period = div_value+1 clock_fpga cycles.
REQ-008 burst_len  input  COUNT_WIDTH  pulses emitted per key press in burst mode.
REQ-009 key0  input  1  pushbutton, active-low, asynchronous to clock_fpga, bouncing.
REQ-010 prog_run  input  1  1 = run; 0 = programming, all pulses suppressed.
REQ-011 hlt_sig  input  1  synchronous halt request from SAP control unit.
REQ-012 clock_sap_en  output  1  single-cycle clock-enable pulse to SAP datapath.
REQ-013 clock_led  output  1  toggles on every clock_sap_en pulse (display).
REQ-014 pulse_count  output  COUNT_WIDTH  number of pulses emitted, wraps modulo 2^COUNT_WIDTH.
REQ-015 busy  output  1  high while a burst is in progress.
REQ-016 halted  output  1  high while in HALTED state.

Function
REQ-017 key0 SHALL pass through a 2-flop synchronizer before any use.
REQ-018 Debounced key level SHALL update only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
REQ-019 A press event SHALL be a single-cycle 1->0 transition of the debounced level; release generates no event.
REQ-020 States: IDLE, AUTO, BURST, HALTED; registered, one-hot or binary at implementer's choice.
REQ-021 Priority each cycle: reset_n > hlt_sig > prog_run=0 > mode.
REQ-022 hlt_sig=1 in any state SHALL enter HALTED next cycle, abort any burst and clear the divider; HALTED exits to IDLE in the first cycle hlt_sig=0.
REQ-023 prog_run=0 SHALL force IDLE, clear divider and burst counter, and suppress clock_sap_en.
REQ-024 IDLE, mode 00: press event in cycle N SHALL produce exactly one clock_sap_en pulse in cycle N+1.
REQ-025 IDLE, mode 01: SHALL enter AUTO; divider counts 0..div_value, clock_sap_en asserted in the cycle the divider equals div_value, divider then returns to 0; div_value=0 gives a pulse every cycle.
REQ-026 IDLE, mode 10: press event SHALL load remaining=burst_len and enter BURST with divider cleared; burst_len=0 SHALL stay in IDLE with no pulse.
REQ-027 BURST: each divider terminal count SHALL pulse and decrement remaining; after the pulse that brings remaining to 0, return to IDLE; press events during BURST are ignored.
REQ-028 Any mode change SHALL clear the divider and return AUTO/BURST to IDLE next cycle; an in-progress burst is aborted.
REQ-029 Mode 11: no pulses; press events discarded.
REQ-030 div_value change mid-count SHALL take effect at the next comparison; if divider already exceeds new value it SHALL wrap to 0 without a pulse.
REQ-031 clock_sap_en SHALL be registered, never combinationally derived from clock_fpga, and never high two cycles in a row except when div_value=0.
REQ-032 pulse_count SHALL increment and clock_led toggle in the same cycle clock_sap_en is high.
REQ-033 busy SHALL equal (state==BURST); halted SHALL equal (state==HALTED).

Reset
REQ-034 reset_n low SHALL immediately set state IDLE, divider 0, remaining 0, debounce counter 0, debounced key level 1, synchronizer flops 1, and all outputs 0.
REQ-035 Reset deassertion SHALL not generate a press event or pulse.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-036 mode=00, prog_run=1, key0 held low 10 cycles with 3 bounces first -> exactly one clock_sap_en pulse, pulse_count=1, clock_led=1.
REQ-037 mode=01, div_value=3, run 40 cycles -> 10 pulses spaced 4 cycles apart, pulse_count=10.
REQ-038 mode=10, burst_len=5, div_value=1, one press -> busy high, 5 pulses 2 cycles apart, busy low after 5th; second press mid-burst ignored.
REQ-039 mode=01 running, hlt_sig pulsed high 3 cycles -> no pulses while halted=1, halted clears one cycle after hlt_sig falls, auto resumes from divider 0.
REQ-040 mode=10 burst in progress, reset_n low 1 cycle asynchronously -> all outputs 0 immediately, no pulses after release until new press.
REQ-041 prog_run=0 with mode=01 and key presses -> zero pulses, pulse_count unchanged.
